ps2_host_tx: RTL and testbench
==============================

// Module: ps2_host_tx
// PURPOSE
//  PS/2 host-to-device transmitter; the transmit counterpart to the keyboard receive path.
//  Sends one command byte to the keyboard (0xED set-LEDs, 0xF4 enable, 0xFF reset) over the shared open-drain clock/data lines.
//  Flags when the keyboard accepts or rejects the byte.
//  Sits beside the PS/2 receiver in the top level; rx_inhibit tells the receiver to ignore line activity while this block owns the bus.
// PARAMETERS
//  INHIBIT_CYCLES  10000    clock cycles ps2_clk held low before the start bit (100 us @ 100 MHz)
//  TIMEOUT_CYCLES  1500000  max cycles between device clock falling edges, and for the final release (15 ms)
//  FILTER_LEN      8        cycles ps2_clk_in must hold a new level before it is accepted
// PORTS
//  clock        in   1  system clock
//  reset        in   1  synchronous, active-high
//  tx_data      in   8  command byte; sampled on accept
//  tx_valid     in   1  request to send
//  tx_ready     out  1  high only in IDLE; accept = tx_valid & tx_ready
//  tx_done      out  1  1-cycle pulse: device ACKed and released the bus
//  tx_error     out  1  1-cycle pulse: transfer aborted
//  err_code     out  2  valid with tx_error: 01 timeout, 10 no ACK; holds until next error
//  ps2_clk_in   in   1  raw ps2_clk pin level (asynchronous)
//  ps2_data_in  in   1  raw ps2_data pin level (asynchronous)
//  ps2_clk_oe   out  1  1 = drive ps2_clk low; 0 = release (top level: oe ? 1'b0 : 1'bz)
//  ps2_data_oe  out  1  1 = drive ps2_data low; 0 = release
//  rx_inhibit   out  1  high in every state except IDLE
// BEHAVIOUR
//  Reset: state IDLE; tx_ready=1 after reset deasserts; tx_done, tx_error, ps2_clk_oe, ps2_data_oe, rx_inhibit = 0; err_code = 00.
//  Reset mid-transfer: both lines released in the cycle after reset; no done/error pulse.
//  Inputs: 2-flop synchroniser on both pins, then a FILTER_LEN stability filter on clock.
//   clk_fall = filtered clock 1->0; latency from pin edge is 2+FILTER_LEN cycles.
//  Shift byte sh[7:0] latched on accept; parity = ~^tx_data (odd). Data is sent LSB first.
//   A bit value of 0 means data_oe=1; a bit value of 1 means data_oe=0.
//  FSM:
//   IDLE: wait for accept, then go to INHIBIT.
//   INHIBIT: clk_oe=1 for INHIBIT_CYCLES; data_oe=1 in the final cycle (start bit); then go to RTS.
//   RTS: clk_oe=0, data_oe=1 held. On clk_fall, drive D0 and go to DATA with bitcnt=0.
//   DATA: on clk_fall, bitcnt++ and drive sh[bitcnt+1]. On the fall after D7 is driven, drive parity and go to PARITY.
//   PARITY: on clk_fall, release data (stop bit) and go to STOP.
//   STOP: on clk_fall, go to ACK.
//   ACK: sample synced data after FILTER_LEN cycles; 0 -> RELEASE; 1 -> error 10, go to IDLE.
//   RELEASE: wait for synced clock=1 and data=1, then pulse tx_done and go to IDLE.
//  Timeout: a cycle counter clears on entry to RTS and on every clk_fall.
//   In RTS..RELEASE, a count reaching TIMEOUT_CYCLES means tx_error, err_code=01, both oe=0, IDLE.
//  Every exit from the FSM releases both lines in the same cycle as the pulse.
//  tx_done and tx_error are never high together.
//  tx_valid held during a transfer is not re-accepted until IDLE, which lasts at least 1 cycle.
//  Device clock edges seen in IDLE or INHIBIT are ignored.
// STRUCTURE
//  ps2_pkg: state encodings, ERR_TIMEOUT/ERR_NOACK, and command constants CMD_SET_LEDS=8'hED, CMD_ENABLE=8'hF4, CMD_RESET=8'hFF.
//  Sub-module ps2_edge_filter: synchroniser + FILTER_LEN debounce; outputs level and fall pulse.
//   Shared later with the receiver.
//  Top: FSM, 4-bit bit counter, timer sized for max(INHIBIT_CYCLES, TIMEOUT_CYCLES), shift register.
// TESTING (sim params: INHIBIT_CYCLES=20, TIMEOUT_CYCLES=400, FILTER_LEN=2)
//  1. Send 0xED; the device model clocks 11 bits and ACKs low.
//     -> bits seen on rising edges: 0,1,0,1,1,0,1,1,1,1; tx_done pulses once; clk_oe is low for exactly 20 cycles.
//  2. Send 0xF4 -> parity bit 0. Send 0xFF -> parity bit 1. Both give tx_done and leave err_code=00.
//  3. Device never clocks after INHIBIT.
//     -> tx_error with err_code=01 at 400 cycles after RTS entry; ps2_clk_oe=ps2_data_oe=0 in the same cycle.
//  4. Device leaves data high in the ACK slot -> tx_error, err_code=10, no tx_done, back to IDLE with tx_ready=1.
//  5. Assert reset during DATA bit 4 -> next cycle both oe=0, rx_inhibit=0, no pulse; a fresh 0xF4 then completes.
//  6. tx_valid held high across 0xED -> exactly one transfer per IDLE visit.
//     A 1-cycle glitch on ps2_clk_in (< FILTER_LEN) does not advance bitcnt.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-transmit FSM states, error codes and the
// keyboard command bytes this host is expected to send.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_RTS,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_ACK,
        ST_RELEASE
    } tx_state_e;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_TIMEOUT = 2'b01;
    localparam logic [1:0] ERR_NOACK   = 2'b10;

    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] CMD_RESET    = 8'hFF;

    // PS/2 frames carry odd parity over the eight data bits.
    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_edge_filter.sv
// Two-flop synchroniser plus stability filter for a PS/2 clock pin.
// A new level must persist for FILTER_LEN cycles before it is accepted;
// fall_o pulses for one cycle when the accepted level goes 1 -> 0.
module ps2_edge_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic pin_i,
    output logic level_o,
    output logic fall_o
);

    localparam int CW = $clog2(FILTER_LEN + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

    logic          meta_q;
    logic          sync_q;
    logic          level_q;
    logic          fall_q;
    logic [CW-1:0] cnt_q;

    // Synchronise the pin, then accept a new level only once it has been stable.
    always_ff @(posedge clock) begin
        if (reset) begin
            meta_q  <= 1'b1;
            sync_q  <= 1'b1;
            level_q <= 1'b1;
            fall_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            meta_q <= pin_i;
            sync_q <= meta_q;
            fall_q <= 1'b0;
            if (sync_q == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                level_q <= sync_q;
                fall_q  <= level_q;
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    assign level_o = level_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter. Inhibits the bus, issues request-to-send,
// shifts one byte plus odd parity out on device clock falls, then checks the
// device ACK and waits for the bus to go idle. All line drives are open-drain
// enables: 1 pulls the line low, 0 releases it.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 10000,
    parameter int TIMEOUT_CYCLES = 1500000,
    parameter int FILTER_LEN     = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_error,
    output logic [1:0] err_code,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       rx_inhibit
);

    localparam int TMAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [TW-1:0] INH_LAST  = TW'(INHIBIT_CYCLES - 1);
    localparam logic [TW-1:0] INH_START = TW'(INHIBIT_CYCLES - 2);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] ACK_LAST  = TW'(FILTER_LEN - 1);

    tx_state_e     state_q;
    logic [TW-1:0] timer_q;
    logic [3:0]    bitcnt_q;
    logic [7:0]    sh_q;
    logic          par_q;
    logic          clk_oe_q;
    logic          data_oe_q;
    logic          done_q;
    logic          err_q;
    logic [1:0]    err_code_q;
    logic          data_meta_q;
    logic          data_sync_q;

    logic clk_level;
    logic clk_fall;
    logic in_watch;
    logic timeout;

    ps2_edge_filter #(
        .FILTER_LEN(FILTER_LEN)
    ) u_clk_filter (
        .clock  (clock),
        .reset  (reset),
        .pin_i  (ps2_clk_in),
        .level_o(clk_level),
        .fall_o (clk_fall)
    );

    // Data pin only needs synchronising; it is sampled at a settled point.
    always_ff @(posedge clock) begin
        if (reset) begin
            data_meta_q <= 1'b1;
            data_sync_q <= 1'b1;
        end else begin
            data_meta_q <= ps2_data_in;
            data_sync_q <= data_meta_q;
        end
    end

    // The device owns the clock from RTS onwards, so the watchdog covers those states.
    assign in_watch = (state_q != ST_IDLE) && (state_q != ST_INHIBIT);
    assign timeout  = in_watch && !clk_fall && (timer_q == TO_LAST);

    // Transmit FSM: timer, shift register and all line/handshake outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            timer_q    <= '0;
            bitcnt_q   <= '0;
            sh_q       <= '0;
            par_q      <= 1'b0;
            clk_oe_q   <= 1'b0;
            data_oe_q  <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if (in_watch) begin
                timer_q <= clk_fall ? '0 : timer_q + TW'(1);
            end
            if (timeout) begin
                err_q      <= 1'b1;
                err_code_q <= ERR_TIMEOUT;
                clk_oe_q   <= 1'b0;
                data_oe_q  <= 1'b0;
                state_q    <= ST_IDLE;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        clk_oe_q  <= 1'b0;
                        data_oe_q <= 1'b0;
                        if (tx_valid) begin
                            sh_q     <= tx_data;
                            par_q    <= odd_parity(tx_data);
                            timer_q  <= '0;
                            clk_oe_q <= 1'b1;
                            state_q  <= ST_INHIBIT;
                        end
                    end
                    ST_INHIBIT: begin
                        timer_q <= timer_q + TW'(1);
                        if (timer_q == INH_LAST) begin
                            clk_oe_q <= 1'b0;
                            timer_q  <= '0;
                            state_q  <= ST_RTS;
                        end else if (timer_q == INH_START) begin
                            data_oe_q <= 1'b1;
                        end
                    end
                    ST_RTS: begin
                        if (clk_fall) begin
                            data_oe_q <= ~sh_q[0];
                            bitcnt_q  <= '0;
                            state_q   <= ST_DATA;
                        end
                    end
                    ST_DATA: begin
                        if (clk_fall) begin
                            if (bitcnt_q == 4'd7) begin
                                data_oe_q <= ~par_q;
                                state_q   <= ST_PARITY;
                            end else begin
                                bitcnt_q  <= bitcnt_q + 4'd1;
                                sh_q      <= {1'b0, sh_q[7:1]};
                                data_oe_q <= ~sh_q[1];
                            end
                        end
                    end
                    ST_PARITY: begin
                        if (clk_fall) begin
                            data_oe_q <= 1'b0;
                            state_q   <= ST_STOP;
                        end
                    end
                    ST_STOP: begin
                        if (clk_fall) begin
                            state_q <= ST_ACK;
                        end
                    end
                    ST_ACK: begin
                        if (timer_q == ACK_LAST) begin
                            if (!data_sync_q) begin
                                state_q <= ST_RELEASE;
                            end else begin
                                err_q      <= 1'b1;
                                err_code_q <= ERR_NOACK;
                                clk_oe_q   <= 1'b0;
                                data_oe_q  <= 1'b0;
                                state_q    <= ST_IDLE;
                            end
                        end
                    end
                    ST_RELEASE: begin
                        if (clk_level && data_sync_q) begin
                            done_q    <= 1'b1;
                            clk_oe_q  <= 1'b0;
                            data_oe_q <= 1'b0;
                            state_q   <= ST_IDLE;
                        end
                    end
                    default: begin
                        clk_oe_q  <= 1'b0;
                        data_oe_q <= 1'b0;
                        state_q   <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign tx_ready    = (state_q == ST_IDLE);
    assign rx_inhibit  = (state_q != ST_IDLE);
    assign tx_done     = done_q;
    assign tx_error    = err_q;
    assign err_code    = err_code_q;
    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: an open-drain bus model plus a simple keyboard that
// clocks the frame, records the line value at the end of each clock-high
// phase, and optionally ACKs.
module tb_ps2_host_tx;
    import ps2_pkg::*;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, tx_done, tx_error;
    logic [1:0] err_code;
    logic       ps2_clk_in, ps2_data_in;
    logic       ps2_clk_oe, ps2_data_oe, rx_inhibit;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;

    assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES(20),
        .TIMEOUT_CYCLES(400),
        .FILTER_LEN    (2)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx_done    (tx_done),
        .tx_error   (tx_error),
        .err_code   (err_code),
        .ps2_clk_in (ps2_clk_in),
        .ps2_data_in(ps2_data_in),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe),
        .rx_inhibit (rx_inhibit)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad = 0;

    int done_cnt = 0;
    int err_cnt = 0;
    int acc_cnt = 0;
    int oe_cnt = 0;
    int overlap_cnt = 0;
    int dirty_cnt = 0;

    always @(negedge clock) begin
        if (tx_done) done_cnt <= done_cnt + 1;
        if (tx_error) err_cnt <= err_cnt + 1;
        if (tx_valid && tx_ready && !reset) acc_cnt <= acc_cnt + 1;
        if (ps2_clk_oe) oe_cnt <= oe_cnt + 1;
        if (tx_done && tx_error) overlap_cnt <= overlap_cnt + 1;
        if ((tx_done || tx_error) && (ps2_clk_oe || ps2_data_oe)) dirty_cnt <= dirty_cnt + 1;
    end

    typedef struct {
        logic [7:0] data;
        bit         ack;
        logic [9:0] seq;   // {parity, D7..D0, start} as seen on the line
        int         ndone;
        int         nerr;
        logic [1:0] code;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [7:0] d);
        tx_data  = d;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
    endtask

    task automatic wait_rts(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (!ps2_clk_oe && ps2_data_oe) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_end(input int d0, input int e0);
        for (int i = 0; i < 300; i++) begin
            if (done_cnt != d0 || err_cnt != e0) break;
            tick();
        end
        repeat (3) tick();
    endtask

    // Keyboard model: np clock pulses of 10 low / 10 high cycles.
    task automatic dev_clock(input int np, input bit ack, input int glitch_k, output logic [10:0] seq);
        seq = '0;
        repeat (5) tick();
        for (int k = 0; k < np; k++) begin
            seq[k] = ps2_data_in;
            if (ack && k == 10) dev_data_low = 1'b1;
            dev_clk_low = 1'b1;
            repeat (10) tick();
            dev_clk_low = 1'b0;
            if (k == glitch_k) begin
                repeat (4) tick();
                dev_clk_low = 1'b1;
                tick();
                dev_clk_low = 1'b0;
                repeat (5) tick();
            end else if (k == 10) begin
                repeat (3) tick();
                dev_data_low = 1'b0;
                repeat (7) tick();
            end else begin
                repeat (10) tick();
            end
        end
    endtask

    initial begin
        logic [10:0] seq;
        logic [10:0] seq2;
        bit ok;
        int d0, e0, o0, a0, cnt;
        bit got;

        vecs[0] = '{CMD_SET_LEDS, 1'b1, 10'b1111011010, 1, 0, 2'b00};
        vecs[1] = '{CMD_ENABLE,   1'b1, 10'b0111101000, 1, 0, 2'b00};
        vecs[2] = '{CMD_RESET,    1'b1, 10'b1111111110, 1, 0, 2'b00};
        vecs[3] = '{CMD_SET_LEDS, 1'b0, 10'b1111011010, 0, 1, 2'b10};
        vecs[4] = '{8'h00,        1'b1, 10'b1000000000, 1, 0, 2'b10};

        // Reset state
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        chk("rst_ready", tx_ready, 1);
        chk("rst_done", tx_done, 0);
        chk("rst_error", tx_error, 0);
        chk("rst_code", err_code, 0);
        chk("rst_clk_oe", ps2_clk_oe, 0);
        chk("rst_data_oe", ps2_data_oe, 0);
        chk("rst_inhibit", rx_inhibit, 0);

        // Table-driven transfers
        for (int i = 0; i < 5; i++) begin
            d0 = done_cnt; e0 = err_cnt; o0 = oe_cnt;
            send(vecs[i].data);
            wait_rts(ok);
            chk($sformatf("v%0d_rts", i), ok, 1);
            chk($sformatf("v%0d_inhibit", i), rx_inhibit, 1);
            dev_clock(11, vecs[i].ack, -1, seq);
            wait_end(d0, e0);
            chk($sformatf("v%0d_bits", i), seq[9:0], vecs[i].seq);
            chk($sformatf("v%0d_stop", i), seq[10], 1);
            chk($sformatf("v%0d_done", i), done_cnt - d0, vecs[i].ndone);
            chk($sformatf("v%0d_err", i), err_cnt - e0, vecs[i].nerr);
            chk($sformatf("v%0d_code", i), err_code, vecs[i].code);
            chk($sformatf("v%0d_ready", i), tx_ready, 1);
            chk($sformatf("v%0d_clk_oe_len", i), oe_cnt - o0, 20);
        end

        // Device never clocks: watchdog fires 400 cycles after RTS
        send(CMD_SET_LEDS);
        wait_rts(ok);
        chk("to_rts", ok, 1);
        cnt = 0; got = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            cnt++;
            if (tx_error) begin
                got = 1'b1;
                break;
            end
        end
        chk("to_seen", got, 1);
        chk("to_cycles", cnt, 400);
        chk("to_code", err_code, 2'b01);
        chk("to_clk_oe", ps2_clk_oe, 0);
        chk("to_data_oe", ps2_data_oe, 0);
        chk("to_no_done", tx_done, 0);
        repeat (3) tick();

        // Reset while D4 of 0xED (a 0) is on the line
        d0 = done_cnt; e0 = err_cnt;
        send(CMD_SET_LEDS);
        wait_rts(ok);
        dev_clock(5, 1'b0, -1, seq);
        chk("mid_data_oe_d4", ps2_data_oe, 1);
        chk("mid_inhibit", rx_inhibit, 1);
        reset = 1'b1;
        tick();
        chk("mid_clk_oe", ps2_clk_oe, 0);
        chk("mid_data_oe", ps2_data_oe, 0);
        chk("mid_inhibit_off", rx_inhibit, 0);
        reset = 1'b0;
        repeat (3) tick();
        chk("mid_no_pulse", (done_cnt - d0) + (err_cnt - e0), 0);
        chk("mid_code_clr", err_code, 0);
        d0 = done_cnt; e0 = err_cnt;
        send(CMD_ENABLE);
        wait_rts(ok);
        dev_clock(11, 1'b1, -1, seq);
        wait_end(d0, e0);
        chk("after_rst_bits", seq[9:0], 10'b0111101000);
        chk("after_rst_done", done_cnt - d0, 1);

        // tx_valid held across a transfer, plus a short clock glitch
        d0 = done_cnt; e0 = err_cnt; a0 = acc_cnt;
        tx_data = CMD_SET_LEDS;
        tx_valid = 1'b1;
        wait_rts(ok);
        dev_clock(11, 1'b1, -1, seq);
        wait_end(d0, e0);
        wait_rts(ok);
        tx_valid = 1'b0;
        chk("held_second_rts", ok, 1);
        dev_clock(11, 1'b1, 3, seq2);
        wait_end(d0 + 1, e0);
        chk("held_bits1", seq[9:0], 10'b1111011010);
        chk("glitch_bits2", seq2[9:0], 10'b1111011010);
        chk("held_accepts", acc_cnt - a0, 2);
        chk("held_done", done_cnt - d0, 2);
        chk("held_err", err_cnt - e0, 0);
        chk("held_code", err_code, 0);

        chk("never_both_pulses", overlap_cnt, 0);
        chk("lines_free_on_exit", dirty_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
